instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  load base_addr into write pointer; honoured only in IDLE
- base_addr  in  32  starting byte address of the instruction memory
- in_valid  in  1  encode request valid
- in_ready  out  1  encoder can accept a request
- op_class  in  3  0 LUI, 1 AUIPC, 2 LOAD, 3 STORE, 4 OPIMM, 5 OP, 6 JAL, 7 BRANCH
- ALUOp  in  4  OP/OPIMM operation: 0 add, 1 sub, 2 slt, 3 sltu, 4 sll, 5 srl, 6 sra, 7 and, 8 or, 9 xor
- funct3  in  3  width/condition for LOAD, STORE and BRANCH
- rs1, rs2, rd  in  5 each  register addresses
- imm  in  32  immediate, byte-offset form
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  32  write byte address
- imem_wdata  out  32  encoded RV32I instruction word
- imem_ready  in  1  memory accepts the write this cycle
- err  out  1  one-cycle pulse on an illegal request
- err_count  out  8  count of illegal requests, saturating

Function
REQ-003 The FSM SHALL have states IDLE, WRITE and ERR.
REQ-004 In IDLE, in_ready SHALL be 1. In WRITE and ERR, in_ready SHALL be 0.
REQ-005 A request SHALL be accepted when in_valid and in_ready are both 1.
- Legal request: register the encoded word, go to WRITE.
- Illegal request: go to ERR.
REQ-006 In WRITE:
- imem_we SHALL be 1.
- imem_wdata and imem_addr SHALL be held stable until imem_ready is 1.
- On the cycle imem_ready is 1: imem_addr increments by 4 (mod 2^32) and the FSM returns to IDLE.
REQ-007 Latency SHALL be one cycle: a request accepted at edge N gives imem_we=1 in the cycle after edge N.
REQ-008 ERR SHALL last exactly one cycle, with err=1 and imem_we=0. err_count SHALL increment, saturating at 255. imem_addr SHALL be unchanged. The FSM then returns to IDLE.
REQ-009 The following requests SHALL be illegal:
- OP with ALUOp greater than 9
- OPIMM with ALUOp equal to 1 or greater than 9
- LOAD with funct3 of 3, 6 or 7
- STORE with funct3 greater than 2
- BRANCH with funct3 of 2 or 3
REQ-010 Opcodes SHALL be: LUI 0110111, AUIPC 0010111, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, JAL 1101111, BRANCH 1100011.
REQ-011 Field placement SHALL be: rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20]. Fields not used by a format SHALL be 0.
REQ-012 OP/OPIMM funct3 SHALL come from ALUOp:
- add/sub 0, sll 1, slt 2, sltu 3, xor 4, srl/sra 5, or 6, and 7
- bit 30 SHALL be 1 only for sub and sra
REQ-013 Immediate placement SHALL be:
- LUI/AUIPC: [31:12]=imm[31:12]
- LOAD and non-shift OPIMM: [31:20]=imm[11:0]
- OPIMM shifts: [24:20]=imm[4:0], [31:25]=0100000 for sra, else 0
- STORE: [31:25]=imm[11:5], [11:7]=imm[4:0]
- BRANCH: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
- JAL: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- imm bit 0 SHALL be ignored for BRANCH and JAL
REQ-014 start SHALL load imem_addr only in IDLE. If start and an accepted in_valid occur in the same cycle, start SHALL take priority and the request SHALL NOT be accepted. start outside IDLE SHALL be ignored.

Reset
REQ-015 When reset is 1 at a clock edge, the FSM SHALL go to IDLE regardless of state, and any pending write SHALL be dropped.
REQ-016 After reset the outputs SHALL be:
- imem_we=0, imem_addr=0, imem_wdata=0
- err=0, err_count=0
- in_ready=1 from the first cycle after reset deasserts

Verification
REQ-017 start with base_addr=0x100, then OPIMM ALUOp=0 rd=1 rs1=0 imm=5 -> imem_wdata=0x00500093 at address 0x100; the next write goes to 0x104.
REQ-018 OP ALUOp=1 rd=3 rs1=1 rs2=2 -> 0x402081B3. JAL rd=1 imm=8 -> 0x008000EF.
REQ-019 BRANCH funct3=0 rs1=1 rs2=2 imm=16 -> 0x00208863.
REQ-020 imem_ready held 0 for 3 cycles during WRITE -> imem_we, imem_wdata and imem_addr stable and in_ready=0; on the cycle imem_ready=1 the address advances by 4.
REQ-021 OP with ALUOp=12 -> no write, err=1 for exactly one cycle, err_count+1, address unchanged. 260 such requests -> err_count=255.
REQ-022 reset asserted during WRITE with imem_ready=0 -> next cycle imem_we=0 and imem_addr=0; no write occurs.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded request fields into a 32-bit word
// and writes it to instruction memory at an auto-incrementing byte address.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op_class,
    input  logic [3:0]  ALUOp,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;

    localparam logic [2:0] CLS_LUI    = 3'd0;
    localparam logic [2:0] CLS_AUIPC  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_OPIMM  = 3'd4;
    localparam logic [2:0] CLS_OP     = 3'd5;
    localparam logic [2:0] CLS_JAL    = 3'd6;
    localparam logic [2:0] CLS_BRANCH = 3'd7;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic            rdy_q, rdy_d;

    logic [2:0]      alu_f3;
    logic [6:0]      alu_f7;
    logic            alu_alt;
    logic            alu_shift;
    logic            alu_ok;
    logic [XLEN-1:0] enc_c;
    logic            legal_c;

    // ALU operation to funct3/funct7 mapping shared by OP and OPIMM
    always_comb begin
        alu_f3    = 3'd0;
        alu_alt   = 1'b0;
        alu_shift = 1'b0;
        alu_ok    = 1'b1;
        case (ALUOp)
            4'd0: alu_f3 = 3'd0;
            4'd1: begin alu_f3 = 3'd0; alu_alt = 1'b1; end
            4'd2: alu_f3 = 3'd2;
            4'd3: alu_f3 = 3'd3;
            4'd4: begin alu_f3 = 3'd1; alu_shift = 1'b1; end
            4'd5: begin alu_f3 = 3'd5; alu_shift = 1'b1; end
            4'd6: begin alu_f3 = 3'd5; alu_shift = 1'b1; alu_alt = 1'b1; end
            4'd7: alu_f3 = 3'd7;
            4'd8: alu_f3 = 3'd6;
            4'd9: alu_f3 = 3'd4;
            default: alu_ok = 1'b0;
        endcase
        alu_f7 = alu_alt ? 7'b0100000 : 7'b0000000;
    end

    // Instruction word assembly and legality check per format
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b1;
        case (op_class)
            CLS_LUI:   enc_c = {imm[31:12], rd, OPC_LUI};
            CLS_AUIPC: enc_c = {imm[31:12], rd, OPC_AUIPC};
            CLS_LOAD: begin
                legal_c = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
                enc_c   = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            end
            CLS_STORE: begin
                legal_c = (funct3 <= 3'd2);
                enc_c   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            end
            CLS_OPIMM: begin
                legal_c = alu_ok && (ALUOp != 4'd1);
                enc_c   = alu_shift ? {alu_f7, imm[4:0], rs1, alu_f3, rd, OPC_OPIMM}
                                    : {imm[11:0], rs1, alu_f3, rd, OPC_OPIMM};
            end
            CLS_OP: begin
                legal_c = alu_ok;
                enc_c   = {alu_f7, rs2, rs1, alu_f3, rd, OPC_OP};
            end
            CLS_JAL: enc_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            CLS_BRANCH: begin
                legal_c = !(funct3 == 3'd2 || funct3 == 3'd3);
                enc_c   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            end
            default: enc_c = '0;
        endcase
    end

    // Next-state and registered-output logic; start wins over a same-cycle request
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                end else if (in_valid) begin
                    if (legal_c) begin
                        wdata_d = enc_c;
                        state_d = WRITE;
                    end else begin
                        state_d = ERR;
                        if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            WRITE: begin
                if (imem_ready) begin
                    addr_d  = addr_q + XLEN'(4);
                    state_d = IDLE;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        we_d  = (state_d == WRITE);
        err_d = (state_d == ERR);
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized checks of instr_encoder against an arithmetic
// model of the RV32I encoding rules and the write-pointer/error bookkeeping.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_class;
    logic [3:0]  ALUOp;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        err;
    logic [7:0]  err_count;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned exp_addr = 0;
    int unsigned exp_cnt  = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op_class(op_class),
        .ALUOp(ALUOp), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .err(err),
        .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_legal(int unsigned cls, int unsigned alu, int unsigned f3);
        case (cls)
            5: return alu <= 9;
            4: return (alu <= 9) && (alu != 1);
            2: return !(f3 inside {3, 6, 7});
            3: return f3 <= 2;
            7: return !(f3 inside {2, 3});
            default: return 1'b1;
        endcase
    endfunction

    function automatic int unsigned ref_word(int unsigned cls, int unsigned alu, int unsigned f3,
                                             int unsigned r1, int unsigned r2, int unsigned d,
                                             int unsigned iv);
        int unsigned opc, af3, alt, w;
        bit shift;
        case (cls)
            0: opc = 'h37; 1: opc = 'h17; 2: opc = 'h03; 3: opc = 'h23;
            4: opc = 'h13; 5: opc = 'h33; 6: opc = 'h6F; default: opc = 'h63;
        endcase
        case (alu)
            1: af3 = 0; 2: af3 = 2; 3: af3 = 3; 4: af3 = 1; 5: af3 = 5;
            6: af3 = 5; 7: af3 = 7; 8: af3 = 6; 9: af3 = 4; default: af3 = 0;
        endcase
        shift = (alu >= 4 && alu <= 6);
        alt   = (alu == 1 || alu == 6) ? 32'h4000_0000 : 0;
        w = opc;
        case (cls)
            0, 1: w += iv & 32'hFFFF_F000 | (d << 7);
            2:    w += ((iv & 'hFFF) << 20) + (r1 << 15) + (f3 << 12) + (d << 7);
            3:    w += (((iv >> 5) & 'h7F) << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12) + ((iv & 'h1F) << 7);
            4:    w += (shift ? (alt + ((iv & 'h1F) << 20)) : ((iv & 'hFFF) << 20))
                       + (r1 << 15) + (af3 << 12) + (d << 7);
            5:    w += alt + (r2 << 20) + (r1 << 15) + (af3 << 12) + (d << 7);
            6:    w += (((iv >> 20) & 1) << 31) + (((iv >> 1) & 'h3FF) << 21)
                       + (((iv >> 11) & 1) << 20) + (((iv >> 12) & 'hFF) << 12) + (d << 7);
            default: w += (((iv >> 12) & 1) << 31) + (((iv >> 5) & 'h3F) << 25) + (r2 << 20)
                       + (r1 << 15) + (f3 << 12) + (((iv >> 1) & 'hF) << 8) + (((iv >> 11) & 1) << 7);
        endcase
        return w;
    endfunction

    // One request; stall = number of WRITE cycles with imem_ready low
    task automatic do_req(input int unsigned cls, input int unsigned alu, input int unsigned f3,
                          input int unsigned r1, input int unsigned r2, input int unsigned d,
                          input int unsigned iv, input int unsigned stall, input string tag);
        int unsigned w;
        op_class = 3'(cls); ALUOp = 4'(alu); funct3 = 3'(f3);
        rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d); imm = iv;
        in_valid = 1'b1; imem_ready = 1'b0;
        step();
        in_valid = 1'b0;
        if (ref_legal(cls, alu, f3)) begin
            w = ref_word(cls, alu, f3, r1, r2, d, iv);
            check({tag, ".we"},    32'(imem_we), 32'd1);
            check({tag, ".wdata"}, imem_wdata, w);
            check({tag, ".addr"},  imem_addr, exp_addr);
            check({tag, ".rdy"},   32'(in_ready), 32'd0);
            for (int i = 0; i < int'(stall); i++) begin
                step();
                check({tag, ".hold_we"},    32'(imem_we), 32'd1);
                check({tag, ".hold_wdata"}, imem_wdata, w);
                check({tag, ".hold_addr"},  imem_addr, exp_addr);
                check({tag, ".hold_rdy"},   32'(in_ready), 32'd0);
            end
            imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            exp_addr += 4;
            check({tag, ".done_we"},   32'(imem_we), 32'd0);
            check({tag, ".done_addr"}, imem_addr, exp_addr);
            check({tag, ".done_rdy"},  32'(in_ready), 32'd1);
        end else begin
            if (exp_cnt < 255) exp_cnt++;
            check({tag, ".err"},    32'(err), 32'd1);
            check({tag, ".err_we"}, 32'(imem_we), 32'd0);
            check({tag, ".err_rdy"}, 32'(in_ready), 32'd0);
            step();
            check({tag, ".err_end"}, 32'(err), 32'd0);
            check({tag, ".cnt"},     32'(err_count), exp_cnt);
            check({tag, ".err_addr"}, imem_addr, exp_addr);
            check({tag, ".err_rdy2"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        op_class = '0; ALUOp = '0; funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
        imm = '0; imem_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst.rdy",   32'(in_ready), 32'd1);
        check("rst.we",    32'(imem_we), 32'd0);
        check("rst.addr",  imem_addr, 32'd0);
        check("rst.wdata", imem_wdata, 32'd0);
        check("rst.err",   32'(err), 32'd0);
        check("rst.cnt",   32'(err_count), 32'd0);

        start = 1'b1; base_addr = 32'h100;
        step();
        start = 1'b0; exp_addr = 32'h100;
        check("start.addr", imem_addr, 32'h100);

        // Known encodings checked against literal words as well as the model
        do_req(4, 0, 0, 0, 0, 1, 5, 0, "addi");
        check("addi.lit", 32'h00500093, ref_word(4, 0, 0, 0, 0, 1, 5));
        check("addi.next", imem_addr, 32'h104);
        do_req(5, 1, 0, 1, 2, 3, 0, 0, "sub");
        check("sub.lit", 32'h402081B3, ref_word(5, 1, 0, 1, 2, 3, 0));
        do_req(6, 0, 0, 0, 0, 1, 8, 0, "jal");
        check("jal.lit", 32'h008000EF, ref_word(6, 0, 0, 0, 0, 1, 8));
        do_req(7, 0, 0, 1, 2, 0, 16, 3, "beq_stall");
        check("beq.lit", 32'h00208863, ref_word(7, 0, 0, 1, 2, 0, 16));
        do_req(5, 12, 0, 1, 2, 3, 0, 0, "op_bad");

        // start and request together: start wins, nothing accepted
        start = 1'b1; base_addr = 32'hFFFF_FFFC; in_valid = 1'b1;
        op_class = 3'd0; imem_ready = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b0; exp_addr = 32'hFFFF_FFFC;
        check("prio.we",   32'(imem_we), 32'd0);
        check("prio.addr", imem_addr, exp_addr);
        check("prio.rdy",  32'(in_ready), 32'd1);
        do_req(0, 0, 0, 0, 0, 7, 32'hABCDE123, 1, "lui_wrap");
        check("wrap.addr", imem_addr, 32'd0);

        // start during WRITE is ignored
        op_class = 3'd1; rd = 5'd2; imm = 32'h12345000; in_valid = 1'b1;
        step();
        in_valid = 1'b0; start = 1'b1; base_addr = 32'hDEAD0000; imem_ready = 1'b1;
        step();
        start = 1'b0; imem_ready = 1'b0; exp_addr += 4;
        check("ign_start.addr", imem_addr, exp_addr);
        check("ign_start.rdy",  32'(in_ready), 32'd1);

        for (int n = 0; n < 300; n++) begin
            do_req($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom, $urandom_range(0, 2), "rand");
        end

        for (int n = 0; n < 260; n++) do_req(5, 12, 0, 1, 2, 3, 0, 0, "sat");
        check("sat.cnt", 32'(err_count), 32'd255);

        // reset in the middle of a stalled write drops it
        op_class = 3'd5; ALUOp = 4'd0; in_valid = 1'b1; imem_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("rstw.we_before", 32'(imem_we), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; exp_addr = 0; exp_cnt = 0;
        check("rstw.we",   32'(imem_we), 32'd0);
        check("rstw.addr", imem_addr, 32'd0);
        check("rstw.cnt",  32'(err_count), 32'd0);
        step();
        check("rstw.we2",  32'(imem_we), 32'd0);
        check("rstw.rdy",  32'(in_ready), 32'd1);
        do_req(3, 0, 2, 4, 5, 0, 32'h7FF, 0, "sw_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
